program_counter: RTL
====================

# program_counter

Fetch-stage program counter that drives `instrn_address` of the instruction memory in the 32-bit single-cycle datapath. Holds the current byte address, selects the next address from sequential (+4), taken branch or jump, honours a stall, and stops fetching at the end of the program image. It also counts issued instructions for bring-up and performance checks.

## Interface
- `RESET_PC`, 32'h0000_0000, address loaded on reset.
- `MEM_BYTES`, 36, instruction memory size in bytes; the last valid word address is `MEM_BYTES-4`.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `stall` input 1: hold the PC and the counter this cycle.
- `branch_en` input 1: the current instruction is a conditional branch.
- `zero` input 1: ALU zero flag; a branch is taken when `branch_en & zero`.
- `branch_offset` input 32: sign-extended word offset.
- `jump_en` input 1: the current instruction is a jump.
- `jump_index` input 26: jump word index.
- `instrn_address` output 32: current PC (byte address) to the instruction memory.
- `pc_plus4` output 32: `instrn_address + 4`, for the link/branch datapath.
- `fetch_valid` output 1: `instrn_address` holds a live instruction.
- `halted` output 1: end of program reached.
- `fault` output 1: illegal control-flow target (see Configuration).
- `instr_count` output 32: number of instructions issued.

## Operation
- States: IDLE, RUN, HALT, FAULT.
- IDLE: entered on reset. `fetch_valid`=0. Moves unconditionally to RUN on the next edge; the PC is not advanced.
- RUN: `fetch_valid`=1. Next-PC priority is stall > jump > taken branch > sequential.
  - Stall: PC held.
  - Jump: `{pc_plus4[31:28], jump_index, 2'b00}`.
  - Taken branch: `pc_plus4 + (branch_offset << 2)`, 32-bit wrap-around add.
  - Sequential: `pc_plus4`.
- End of program: if the sequential next PC is greater than `MEM_BYTES-4`:
  - The PC is held.
  - The state moves to HALT.
- HALT: `fetch_valid`=0, `halted`=1, and the PC is frozen. Only reset leaves this state.
- FAULT: `fetch_valid`=0, `fault`=1, and the PC is frozen at the offending instruction. Only reset leaves this state.
- `instr_count`:
  - Increments on every edge where the state is RUN and `stall`=0.
  - Saturates at 32'hFFFF_FFFF.
- Jump or branch asserted while `stall`=1: ignored. Control must re-present the jump or branch after the stall.

## Timing
- Reset values:
  - `instrn_address`=`RESET_PC` and `pc_plus4`=`RESET_PC+4`.
  - `fetch_valid`, `halted`, `fault` = 0.
  - `instr_count` = 0.
  - State = IDLE.
- `instrn_address` is a register output. The instruction memory is combinational, so the instruction is valid in the same cycle.
- Next PC is computed combinationally from same-cycle control inputs and is loaded at the following edge. The redirect latency is 1 edge, with no delay slot.
- After reset release there is one IDLE bubble: the first instruction at `RESET_PC` is issued on the 2nd cycle.
- `rst_n`=0 at any edge, in any state, overrides everything, including mid-stall, HALT and FAULT.

## Configuration
- `PC_FAULT_EN` defined:
  - A jump or taken-branch target that is misaligned (`[1:0]`≠0) or greater than `MEM_BYTES-4` enters FAULT.
  - `fault`=1 and the PC is not updated.
- `PC_FAULT_EN` undefined:
  - Target bits `[1:0]` are forced to 00.
  - An out-of-range target enters HALT, the same as end of program.
  - `fault` is tied to 0 and the FAULT state is absent.

## Structure
- Package `pc_pkg`:
  - Enum `pc_state_t` (IDLE/RUN/HALT/FAULT).
  - `PC_STEP`=4.
  - Jump-target concatenation function.
- Sub-module `pc_next_calc`: combinational next-PC mux and range/alignment check. The state machine, PC register and counter stay in `program_counter`.

## Test plan
- Reset then run with `MEM_BYTES`=36:
  - The address sequence is 0 (IDLE), 0, 4, 8, …, 32.
  - Then `halted`=1, address stays 32, and `instr_count`=9.
- Taken branch: at PC=8, `branch_en`=1, `zero`=1, offset=2 → next address 20. Same with `zero`=0 → next address 12.
- Jump wins over branch: at PC=4, `jump_en`=1, `branch_en`=1, `zero`=1, `jump_index`=6 → next address 24.
- Stall: stall for 3 cycles at PC=12 → address stays 12 and `instr_count` is unchanged; after release the next address is 16.
- Fault:
  - With `PC_FAULT_EN` defined: jump to index 20 (byte 80) → `fault`=1 and PC is held.
  - Without it: the same jump gives `halted`=1.
- Reset mid-run: `rst_n`=0 for 1 edge at PC=20 → address 0, `instr_count`=0, one IDLE bubble, then normal fetch resumes.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types, constants and helpers for the fetch-stage program counter.
// Optional feature macro: PC_FAULT_EN (adds the FAULT state for illegal control-flow targets).
package pc_pkg;

  // Byte distance between consecutive 32-bit instructions.
  localparam logic [31:0] PC_STEP = 32'd4;

`ifdef PC_FAULT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } pc_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } pc_state_t;
`endif

  // Jump target: upper nibble of the sequential PC, word index, byte alignment.
  function automatic logic [31:0] jump_target(input logic [31:0] i_pc_plus4,
                                              input logic [25:0] i_index);
    return {i_pc_plus4[31:28], i_index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection (jump > taken branch > sequential)
// plus range / alignment check of the selected target.
// Optional feature macro: PC_FAULT_EN (report misaligned targets instead of masking them).
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 36
) (
  input  logic [31:0] i_pc_plus4,
  input  logic        i_branch_en,
  input  logic        i_zero,
  input  logic [31:0] i_branch_offset,
  input  logic        i_jump_en,
  input  logic [25:0] i_jump_index,
  output logic [31:0] o_target,
  output logic        o_redirect,
  output logic        o_target_bad,
  output logic        o_seq_end
);

  // Highest byte address that still holds an instruction word.
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES) - PC_STEP;

  logic [31:0] w_raw;

  // Pick the raw next address; jump outranks a taken branch.
  always_comb begin
    w_raw      = i_pc_plus4;
    o_redirect = 1'b0;
    if (i_jump_en) begin
      w_raw      = jump_target(i_pc_plus4, i_jump_index);
      o_redirect = 1'b1;
    end else if (i_branch_en & i_zero) begin
      w_raw      = i_pc_plus4 + (i_branch_offset << 2);
      o_redirect = 1'b1;
    end else begin
      w_raw      = i_pc_plus4;
      o_redirect = 1'b0;
    end
  end

`ifdef PC_FAULT_EN
  // Misaligned or out-of-image redirects are reported, never silently fixed.
  assign o_target     = w_raw;
  assign o_target_bad = o_redirect & ((w_raw[1:0] != 2'b00) | (w_raw > LAST_ADDR));
`else
  // Without fault reporting the target is forced word-aligned; only range matters.
  assign o_target     = w_raw & ~32'h0000_0003;
  assign o_target_bad = o_redirect & (o_target > LAST_ADDR);
`endif

  // Falling off the end of the program image on a sequential step.
  assign o_seq_end = (i_pc_plus4 > LAST_ADDR);

endmodule

// File: rtl/program_counter.sv
// program_counter: fetch-stage PC with IDLE bubble after reset, stall, jump/branch
// redirect, end-of-program halt and a saturating issued-instruction counter.
// Optional feature macro: PC_FAULT_EN (illegal redirect targets enter FAULT).
module program_counter
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 36
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_en,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  output logic [31:0] instrn_address,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  pc_state_t   r_state;
  pc_state_t   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_count;
  logic        r_fetch_valid;
  logic        r_halted;
  logic [31:0] w_pc_nxt;
  logic        w_count_inc;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_target_bad;
  logic        w_seq_end;

  pc_next_calc #(
    .MEM_BYTES (MEM_BYTES)
  ) u_next (
    .i_pc_plus4      (r_pc_plus4),
    .i_branch_en     (branch_en),
    .i_zero          (zero),
    .i_branch_offset (branch_offset),
    .i_jump_en       (jump_en),
    .i_jump_index    (jump_index),
    .o_target        (w_target),
    .o_redirect      (w_redirect),
    .o_target_bad    (w_target_bad),
    .o_seq_end       (w_seq_end)
  );

  // Next state, next PC and counter enable; stall outranks every redirect.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_count_inc = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (stall) begin
          w_state_nxt = RUN;
        end else begin
          w_count_inc = 1'b1;
          if (w_redirect && w_target_bad) begin
`ifdef PC_FAULT_EN
            w_state_nxt = FAULT;
`else
            w_state_nxt = HALT;
`endif
          end else if (w_redirect) begin
            w_pc_nxt = w_target;
          end else if (w_seq_end) begin
            w_state_nxt = HALT;
          end else begin
            w_pc_nxt = w_target;
          end
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
`ifdef PC_FAULT_EN
      FAULT: begin
        w_state_nxt = FAULT;
      end
`endif
      default: begin
        w_state_nxt = IDLE;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  // State, PC, counter and status flags; reset is synchronous and wins in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_pc_plus4    <= RESET_PC + PC_STEP;
      r_count       <= 32'd0;
      r_fetch_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pc_plus4    <= w_pc_nxt + PC_STEP;
      r_fetch_valid <= (w_state_nxt == RUN);
      r_halted      <= (w_state_nxt == HALT);
      if (w_count_inc && (r_count != 32'hFFFF_FFFF)) begin
        r_count <= r_count + 32'd1;
      end else begin
        r_count <= r_count;
      end
    end
  end

`ifdef PC_FAULT_EN
  logic r_fault;

  // Fault flag follows entry into the FAULT state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= (w_state_nxt == FAULT);
    end
  end

  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  assign instrn_address = r_pc;
  assign pc_plus4       = r_pc_plus4;
  assign fetch_valid    = r_fetch_valid;
  assign halted         = r_halted;
  assign instr_count    = r_count;

endmodule
